// File: rtl/imem_stream_loader_if.sv
// Program word stream into the imem loader: valid/ready handshake plus data and
// last-word marker.
interface imem_stream_loader_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;

   modport master (output s_valid, output s_data, output s_last, input s_ready);
   modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/imem_stream_loader.sv
// Streams program words into the instruction memory write port from START_BYTE_ADDR
// and holds the core in reset until the final word has landed.
module imem_stream_loader #(
   parameter int unsigned MEM_DEPTH       = 1024,
   parameter logic [31:0] START_BYTE_ADDR = 32'h0000_3000,
   parameter int unsigned CNT_W           = $clog2(MEM_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   imem_stream_loader_if.slave  s,
   input  logic                 reload,
   output logic                 imem_wen,
   output logic [31:0]          imem_waddr,
   output logic [31:0]          imem_wdata,
   output logic                 core_rst_n,
   output logic                 load_done,
   output logic                 load_error,
   output logic [CNT_W-1:0]     word_count
);

   typedef enum logic [1:0] {
      LOAD,
      DRAIN,
      RUN,
      ERROR
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   wc_q, wc_d;
   logic               wen_q, wen_d;
   logic [31:0]        waddr_q, waddr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               core_rst_n_q, core_rst_n_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   assign s.s_ready = (state_q == LOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= LOAD;
         wc_q         <= '0;
         wen_q        <= 1'b0;
         waddr_q      <= START_BYTE_ADDR;
         wdata_q      <= '0;
         core_rst_n_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wc_q         <= wc_d;
         wen_q        <= wen_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         core_rst_n_q <= core_rst_n_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wc_d         = wc_q;
      wen_d        = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      core_rst_n_d = core_rst_n_q;
      done_d       = done_q;
      err_d        = err_q;

      unique case (state_q)
         LOAD: begin
            if (s.s_valid) begin
               if (wc_q < CNT_W'(MEM_DEPTH)) begin
                  wen_d   = 1'b1;
                  waddr_d = START_BYTE_ADDR + (32'(wc_q) << 2);
                  wdata_d = s.s_data;
                  wc_d    = wc_q + CNT_W'(1);
                  if (s.s_last) state_d = DRAIN;
               end else begin
                  // Memory full: drop the word and lock up until external reset.
                  state_d = ERROR;
                  err_d   = 1'b1;
               end
            end
         end
         DRAIN: begin
            state_d      = RUN;
            core_rst_n_d = 1'b1;
            done_d       = 1'b1;
         end
         RUN: begin
            if (reload) begin
               state_d      = LOAD;
               core_rst_n_d = 1'b0;
               done_d       = 1'b0;
               wc_d         = '0;
            end
         end
         ERROR: begin
            core_rst_n_d = 1'b0;
         end
         default: state_d = LOAD;
      endcase
   end

   assign imem_wen   = wen_q;
   assign imem_waddr = waddr_q;
   assign imem_wdata = wdata_q;
   assign core_rst_n = core_rst_n_q;
   assign load_done  = done_q;
   assign load_error = err_q;
   assign word_count = wc_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: a default-depth instance and a 4-word
// instance, with expected imem writes scoreboarded per instance.
module tb_imem_stream_loader;

   logic clk;
   logic rst_n;
   logic reload0, reload4;

   logic        wen0, core0, done0, err0;
   logic [31:0] waddr0, wdata0;
   logic [10:0] wc0;
   logic        wen4, core4, done4, err4;
   logic [31:0] waddr4, wdata4;
   logic [2:0]  wc4;

   int checks = 0;
   int errors = 0;
   logic [63:0] q0[$];
   logic [63:0] q4[$];

   imem_stream_loader_if sif0 ();
   imem_stream_loader_if sif4 ();

   imem_stream_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s          (sif0.slave),
      .reload     (reload0),
      .imem_wen   (wen0),
      .imem_waddr (waddr0),
      .imem_wdata (wdata0),
      .core_rst_n (core0),
      .load_done  (done0),
      .load_error (err0),
      .word_count (wc0)
   );

   imem_stream_loader #(.MEM_DEPTH(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .s          (sif4.slave),
      .reload     (reload4),
      .imem_wen   (wen4),
      .imem_waddr (waddr4),
      .imem_wdata (wdata4),
      .core_rst_n (core4),
      .load_done  (done4),
      .load_error (err4),
      .word_count (wc4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock and reconcile each instance's write port with its scoreboard.
   task automatic tick();
      logic [63:0] e;
      @(posedge clk);
      #1;
      check("wen0_vs_pending", wen0, q0.size() != 0);
      if (wen0 && q0.size() != 0) begin
         e = q0.pop_front();
         check("write0_addr_data", {waddr0, wdata0}, e);
      end
      check("wen4_vs_pending", wen4, q4.size() != 0);
      if (wen4 && q4.size() != 0) begin
         e = q4.pop_front();
         check("write4_addr_data", {waddr4, wdata4}, e);
      end
   endtask

   task automatic send0(input logic [31:0] d, input logic l, input logic [31:0] a);
      sif0.s_valid = 1'b1;
      sif0.s_data  = d;
      sif0.s_last  = l;
      check("ready0_on_send", sif0.s_ready, 1'b1);
      q0.push_back({a, d});
      tick();
   endtask

   task automatic send4(input logic [31:0] d, input logic [31:0] a);
      sif4.s_valid = 1'b1;
      sif4.s_data  = d;
      sif4.s_last  = 1'b0;
      check("ready4_on_send", sif4.s_ready, 1'b1);
      q4.push_back({a, d});
      tick();
   endtask

   task automatic check_reset0(input string tag);
      check({tag, "_wen0"},   wen0,   1'b0);
      check({tag, "_waddr0"}, waddr0, 32'h0000_3000);
      check({tag, "_wdata0"}, wdata0, 32'h0);
      check({tag, "_core0"},  core0,  1'b0);
      check({tag, "_done0"},  done0,  1'b0);
      check({tag, "_err0"},   err0,   1'b0);
      check({tag, "_wc0"},    wc0,    11'd0);
      check({tag, "_ready0"}, sif0.s_ready, 1'b1);
   endtask

   task automatic pulse_reload0();
      reload0 = 1'b1;
      tick();
      reload0 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      reload0 = 1'b0; reload4 = 1'b0;
      sif0.s_valid = 1'b0; sif0.s_data = '0; sif0.s_last = 1'b0;
      sif4.s_valid = 1'b0; sif4.s_data = '0; sif4.s_last = 1'b0;
      tick();
      tick();
      check_reset0("reset");
      check("reset_err4",   err4,  1'b0);
      check("reset_core4",  core4, 1'b0);
      check("reset_waddr4", waddr4, 32'h0000_3000);
      rst_n = 1'b1;

      // Back-to-back three-word program.
      send0(32'h2401_0001, 1'b0, 32'h0000_3000);
      send0(32'h2402_0002, 1'b0, 32'h0000_3004);
      send0(32'h0022_1820, 1'b1, 32'h0000_3008);
      sif0.s_valid = 1'b0; sif0.s_last = 1'b0;
      check("b2b_drain_core0",  core0, 1'b0);
      check("b2b_drain_ready0", sif0.s_ready, 1'b0);
      check("b2b_wc0",          wc0, 11'd3);
      tick();
      check("b2b_run_core0", core0, 1'b1);
      check("b2b_run_done0", done0, 1'b1);
      check("b2b_run_wc0",   wc0, 11'd3);
      sif0.s_valid = 1'b1;
      check("run_ready0", sif0.s_ready, 1'b0);
      tick();
      sif0.s_valid = 1'b0;
      check("run_ignore_wc0", wc0, 11'd3);

      // Overflow on the 4-deep instance.
      send4(32'hA000_0000, 32'h0000_3000);
      send4(32'hA000_0001, 32'h0000_3004);
      send4(32'hA000_0002, 32'h0000_3008);
      send4(32'hA000_0003, 32'h0000_300C);
      sif4.s_valid = 1'b1;
      sif4.s_data  = 32'hA000_0004;
      sif4.s_last  = 1'b1;
      check("ovf_ready4_full", sif4.s_ready, 1'b1);
      tick();
      check("ovf_err4",   err4, 1'b1);
      check("ovf_core4",  core4, 1'b0);
      check("ovf_ready4", sif4.s_ready, 1'b0);
      check("ovf_wc4",    wc4, 3'd4);
      check("ovf_done4",  done4, 1'b0);
      sif4.s_valid = 1'b0; sif4.s_last = 1'b0;
      reload4 = 1'b1;
      tick();
      reload4 = 1'b0;
      tick();
      tick();
      check("ovf_hold_err4",   err4, 1'b1);
      check("ovf_hold_ready4", sif4.s_ready, 1'b0);
      check("ovf_hold_core4",  core4, 1'b0);

      // Reload, then the same program with gaps and a reload pulse mid-load.
      pulse_reload0();
      check("reload_core0",  core0, 1'b0);
      check("reload_done0",  done0, 1'b0);
      check("reload_wc0",    wc0, 11'd0);
      check("reload_ready0", sif0.s_ready, 1'b1);
      send0(32'h2401_0001, 1'b0, 32'h0000_3000);
      sif0.s_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("gap_core0", core0, 1'b0);
      end
      send0(32'h2402_0002, 1'b0, 32'h0000_3004);
      sif0.s_valid = 1'b0;
      tick();
      pulse_reload0();
      check("load_reload_ready0", sif0.s_ready, 1'b1);
      check("load_reload_wc0",    wc0, 11'd2);
      check("load_reload_core0",  core0, 1'b0);
      send0(32'h0022_1820, 1'b1, 32'h0000_3008);
      sif0.s_valid = 1'b0; sif0.s_last = 1'b0;
      check("gap_drain_core0", core0, 1'b0);
      tick();
      check("gap_run_core0", core0, 1'b1);
      check("gap_run_wc0",   wc0, 11'd3);

      // Reload with a two-word program.
      pulse_reload0();
      check("reload2_core0", core0, 1'b0);
      send0(32'h1111_1111, 1'b0, 32'h0000_3000);
      send0(32'h2222_2222, 1'b1, 32'h0000_3004);
      sif0.s_valid = 1'b0; sif0.s_last = 1'b0;
      tick();
      check("two_run_core0", core0, 1'b1);
      check("two_run_done0", done0, 1'b1);
      check("two_run_wc0",   wc0, 11'd2);

      // Single-word program of all zeros.
      pulse_reload0();
      send0(32'h0000_0000, 1'b1, 32'h0000_3000);
      sif0.s_valid = 1'b0; sif0.s_last = 1'b0;
      tick();
      check("single_done0", done0, 1'b1);
      check("single_core0", core0, 1'b1);
      check("single_wc0",   wc0, 11'd1);

      // Asynchronous reset partway through a four-word load.
      pulse_reload0();
      send0(32'hCAFE_0000, 1'b0, 32'h0000_3000);
      send0(32'hCAFE_0001, 1'b0, 32'h0000_3004);
      sif0.s_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset0("async");
      check("async_err4",   err4, 1'b0);
      check("async_ready4", sif4.s_ready, 1'b1);
      tick();
      rst_n = 1'b1;
      send0(32'hBEEF_0000, 1'b0, 32'h0000_3000);
      send0(32'hBEEF_0001, 1'b0, 32'h0000_3004);
      send0(32'hBEEF_0002, 1'b0, 32'h0000_3008);
      send0(32'hBEEF_0003, 1'b1, 32'h0000_300C);
      sif0.s_valid = 1'b0; sif0.s_last = 1'b0;
      tick();
      check("restart_core0", core0, 1'b1);
      check("restart_wc0",   wc0, 11'd4);

      check("sb0_empty", q0.size(), 0);
      check("sb4_empty", q4.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
